// File: rtl/bus_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bus_master_if: MEM-stage to system-bus sequencer (request/grant, one bus   |
// | cycle with wait states, read-data buffer, slave timeout).                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bus_master_if #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        stall,
  input  logic        flush,
  input  logic        as_,
  input  logic        rw,
  input  logic [29:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        bus_err,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic [29:0] bus_addr,
  output logic        bus_as_,
  output logic        bus_rw,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    STALL  = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_as_q, bus_as_d;
  logic        bus_rw_q, bus_rw_d;
  logic [29:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wr_data_q, bus_wr_data_d;
  logic [31:0] rd_buf_q, rd_buf_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q       <= IDLE;
      bus_req_q     <= 1'b1;
      bus_as_q      <= 1'b1;
      bus_rw_q      <= 1'b1;
      bus_addr_q    <= 30'd0;
      bus_wr_data_q <= 32'd0;
      rd_buf_q      <= 32'd0;
      tmo_cnt_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_as_q      <= bus_as_d;
      bus_rw_q      <= bus_rw_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      rd_buf_q      <= rd_buf_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_as_d      = bus_as_q;
    bus_rw_d      = bus_rw_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    rd_buf_d      = rd_buf_q;
    tmo_cnt_d     = tmo_cnt_q;
    busy          = 1'b0;
    bus_err       = 1'b0;
    rd_data       = rd_buf_q;

    unique case (state_q)
      IDLE: begin
        if (!as_ && !flush) begin
          busy          = 1'b1;
          state_d       = REQ;
          bus_req_d     = 1'b0;
          bus_addr_d    = addr;
          bus_rw_d      = rw;
          bus_wr_data_d = wr_data;
        end
      end
      REQ: begin
        busy = 1'b1;
        if (flush) begin
          bus_req_d = 1'b1;
          state_d   = IDLE;
        end else if (!bus_grnt_) begin
          bus_as_d  = 1'b0;
          tmo_cnt_d = 8'd0;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        // Strobe is a single-cycle pulse; flush cannot abort a started cycle.
        bus_as_d = 1'b1;
        if (!bus_rdy_) begin
          rd_data   = bus_rd_data;
          bus_req_d = 1'b1;
          if (bus_rw_q) rd_buf_d = bus_rd_data;
          state_d = stall ? STALL : IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          bus_err   = 1'b1;
          bus_req_d = 1'b1;
          state_d   = stall ? STALL : IDLE;
        end else begin
          busy      = 1'b1;
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      STALL: begin
        // as_ still belongs to the completed instruction here.
        if (!stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_req_    = bus_req_q;
  assign bus_as_     = bus_as_q;
  assign bus_rw      = bus_rw_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wr_data = bus_wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bus_master_if: transaction-level reference model bench for             |
// | bus_master_if (directed scenarios followed by randomized transactions).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bus_master_if;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset_, stall, flush, as_, rw, bus_grnt_, bus_rdy_;
  logic [29:0] addr;
  logic [31:0] wr_data, bus_rd_data;
  logic [31:0] rd_data, bus_wr_data;
  logic        busy, bus_err, bus_req_, bus_as_, bus_rw;
  logic [29:0] bus_addr;

  bus_master_if #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_(reset_), .stall(stall), .flush(flush), .as_(as_), .rw(rw),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .bus_err(bus_err),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr), .bus_as_(bus_as_),
    .bus_rw(bus_rw), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_busy = 0, n_as = 0, n_err = 0;

  // Expected outputs for the current cycle, written by the stimulus process.
  logic        chk_en = 1'b0;
  logic        e_busy, e_err, e_req_, e_as_, e_rw;
  logic [31:0] e_rd_data, e_wdata;
  logic [29:0] e_addr;
  logic [31:0] m_rd_buf;

  logic        pin_valid = 1'b0;
  string       pin_nm;
  logic [31:0] pin_act, pin_exp;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      cmp("busy", 32'(busy), 32'(e_busy));
      cmp("bus_err", 32'(bus_err), 32'(e_err));
      cmp("bus_req_", 32'(bus_req_), 32'(e_req_));
      cmp("bus_as_", 32'(bus_as_), 32'(e_as_));
      cmp("bus_rw", 32'(bus_rw), 32'(e_rw));
      cmp("bus_addr", 32'(bus_addr), 32'(e_addr));
      cmp("bus_wr_data", bus_wr_data, e_wdata);
      cmp("rd_data", rd_data, e_rd_data);
      n_busy += int'(busy);
      n_as   += int'(!bus_as_);
      n_err  += int'(bus_err);
    end
    if (pin_valid) cmp(pin_nm, pin_act, pin_exp);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic b, input logic rq, input logic as, input logic er,
                            input logic [31:0] rd);
    e_busy = b; e_req_ = rq; e_as_ = as; e_err = er; e_rd_data = rd;
  endtask

  task automatic model_reset();
    m_rd_buf = 32'd0; e_addr = 30'd0; e_rw = 1'b1; e_wdata = 32'd0;
    expect_out(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
  endtask

  // Idle cycles: either no strobe, or a strobe masked by flush.
  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) begin
      as_ = 1'($urandom); flush = !as_; stall = 1'b0;
      bus_grnt_ = 1'b1; bus_rdy_ = 1'($urandom); bus_rd_data = $urandom;
      expect_out(1'b0, 1'b1, 1'b1, 1'b0, m_rd_buf);
      cyc();
    end
  endtask

  task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp);
    pin_nm = nm; pin_act = act; pin_exp = exp; pin_valid = 1'b1;
    idle_cyc(1);
    pin_valid = 1'b0;
  endtask

  // One access: g REQ cycles without grant, w wait states, s STALL cycles,
  // flush in REQ cycle f (0 = none), async reset in ACCESS cycle ab (0 = none).
  task automatic run_txn(input logic r, input logic [29:0] a, input logic [31:0] wd,
                         input int g, input int w, input int s, input int f,
                         input logic [31:0] rv, input int ab);
    int  nreq, nacc;
    logic ok, last;
    as_ = 1'b0; rw = r; addr = a; wr_data = wd; flush = 1'b0; stall = 1'b0;
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = $urandom;
    expect_out(1'b1, 1'b1, 1'b1, 1'b0, m_rd_buf);
    cyc();
    e_addr = a; e_rw = r; e_wdata = wd;

    nreq = (f > 0) ? f : g + 1;
    for (int k = 1; k <= nreq; k++) begin
      flush = (k == f); bus_grnt_ = (k == g + 1) ? 1'b0 : 1'b1;
      addr = 30'($urandom); wr_data = $urandom; rw = 1'($urandom);
      expect_out(1'b1, 1'b0, 1'b1, 1'b0, m_rd_buf);
      cyc();
    end
    if (f > 0) begin
      as_ = 1'b1; flush = 1'b0; bus_grnt_ = 1'b1;
      expect_out(1'b0, 1'b1, 1'b1, 1'b0, m_rd_buf);
      cyc();
      return;
    end

    ok   = (w + 1 <= TO);
    nacc = ok ? w + 1 : TO;
    for (int j = 1; j <= nacc; j++) begin
      last = (j == nacc);
      flush = 1'($urandom); bus_grnt_ = 1'b0;
      bus_rdy_ = (ok && last) ? 1'b0 : 1'b1;
      bus_rd_data = last ? rv : $urandom;
      stall = last && (s > 0);
      expect_out(!last, 1'b0, (j == 1) ? 1'b0 : 1'b1, last && !ok,
                 (last && ok) ? rv : m_rd_buf);
      if (j == ab) begin
        as_ = 1'b1; flush = 1'b0;
        #1 reset_ = 1'b0;
        model_reset();
        cyc();
        reset_ = 1'b1;
        return;
      end
      cyc();
      if (last && ok && r) m_rd_buf = rv;
    end

    for (int m = 1; m <= s; m++) begin
      stall = (m < s); as_ = 1'b0; flush = 1'($urandom);
      bus_grnt_ = 1'b1; bus_rdy_ = 1'($urandom); bus_rd_data = $urandom;
      expect_out(1'b0, 1'b1, 1'b1, 1'b0, m_rd_buf);
      cyc();
    end
  endtask

  initial begin
    int b0, a0, r0;
    reset_ = 1'b0; as_ = 1'b1; rw = 1'b0; addr = '0; wr_data = '0; stall = 1'b0;
    flush = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
    model_reset();
    chk_en = 1'b1;
    cyc(); cyc();
    reset_ = 1'b1;
    idle_cyc(2);

    // Read with 2 wait states, one STALL cycle.
    b0 = n_busy; a0 = n_as;
    run_txn(1'b1, 30'h100, 32'h0, 0, 2, 1, 0, 32'hDEADBEEF, 0);
    pin("read_busy_cycles", 32'(n_busy - b0), 32'd4);
    pin("read_as_cycles", 32'(n_as - a0), 32'd1);
    pin("read_model_buf", m_rd_buf, 32'hDEADBEEF);

    // Write followed by 3 STALL cycles; read buffer untouched.
    run_txn(1'b0, 30'h2A, 32'h12345678, 0, 1, 3, 0, 32'hFFFF0000, 0);
    pin("write_keeps_rd_buf", rd_data, 32'hDEADBEEF);

    // Flush in REQ cycle 3 while grant is withheld.
    b0 = n_busy; a0 = n_as;
    run_txn(1'b1, 30'h3C, 32'h0, 5, 0, 0, 3, 32'h11111111, 0);
    pin("flush_as_cycles", 32'(n_as - a0), 32'd0);
    pin("flush_busy_cycles", 32'(n_busy - b0), 32'd4);

    // Slave never ready: timeout in ACCESS cycle 4.
    r0 = n_err; b0 = n_busy;
    run_txn(1'b1, 30'h3, 32'h0, 1, 10, 0, 0, 32'h22222222, 0);
    pin("timeout_err_cycles", 32'(n_err - r0), 32'd1);
    pin("timeout_busy_cycles", 32'(n_busy - b0), 32'd6);
    pin("timeout_keeps_rd", rd_data, 32'hDEADBEEF);

    // Async reset in the second ACCESS cycle, then a normal read.
    run_txn(1'b1, 30'h55, 32'h0, 0, 2, 0, 0, 32'h33333333, 2);
    pin("reset_clears_rd", rd_data, 32'h0);
    run_txn(1'b1, 30'h56, 32'h0, 0, 0, 0, 0, 32'hBEEF0001, 0);
    pin("after_reset_read", rd_data, 32'hBEEF0001);

    // Back-to-back reads.
    run_txn(1'b1, 30'h0, 32'h0, 0, 0, 0, 0, 32'hA5A50000, 0);
    pin("b2b_model_first", m_rd_buf, 32'hA5A50000);
    run_txn(1'b1, 30'h0, 32'h0, 0, 0, 0, 0, 32'hA5A50000, 0);
    run_txn(1'b1, 30'h1, 32'h0, 0, 0, 0, 0, 32'h5A5A1111, 0);
    pin("b2b_second", rd_data, 32'h5A5A1111);

    for (int t = 0; t < 200; t++) begin
      int g, f, ab;
      g  = $urandom_range(0, 3);
      f  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, g + 1) : 0;
      ab = ($urandom_range(0, 19) == 0) ? 1 : 0;
      run_txn(1'($urandom), 30'($urandom), $urandom, g, $urandom_range(0, 5),
              $urandom_range(0, 2), f, $urandom, ab);
      if ($urandom_range(0, 2) == 0) idle_cyc($urandom_range(1, 2));
    end

    chk_en = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
